// File: rtl/usb_uart_fifo_pkg.sv
// Shared definitions for the USB CDC UART byte-buffering stage:
// FSM state encodings and default FIFO depths.
package usb_uart_fifo_pkg;

    localparam int TX_AW_DEFAULT = 4;
    localparam int RX_AW_DEFAULT = 4;

    typedef enum logic {
        T_IDLE = 1'b0,
        T_WAIT = 1'b1
    } tx_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_WAIT = 1'b1
    } rx_state_t;

endpackage

// File: rtl/usb_uart_fifo_byte_fifo.sv
// Circular byte FIFO with show-ahead head, occupancy count and a
// synchronous flush. A pop frees the slot a simultaneous push fills,
// so push and pop together are accepted even when full.
module byte_fifo #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic [7:0]    push_data,
    input  logic          pop,
    output logic [7:0]    head_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);

    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    logic [7:0]    mem [2**AW];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_pop;
    logic          do_push;

    // Qualify strobes: pops on empty and pushes on full (without a pop) are ignored
    always_comb begin
        do_pop  = pop && (count != '0) && !flush;
        do_push = push && ((count != DEPTH) || do_pop) && !flush;
    end

    // Storage write
    // NOTE: the data array has no reset; count and pointers alone define validity,
    // so leaving it unreset keeps it mappable to plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping
    // NOTE: state is updated with non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head_data = mem[rd_ptr];
    assign full      = (count == DEPTH);
    assign empty     = (count == '0);
    assign level     = count;

endmodule

// File: rtl/usb_uart_fifo.sv
// TX/RX byte buffering between the CPU port and the USB CDC UART core.
// TX bytes drain to the core whenever it is idle and the host is present;
// RX bytes are pulled from the core whenever the RX FIFO has room.
module usb_uart_fifo
    import usb_uart_fifo_pkg::*;
#(
    parameter int TX_AW = TX_AW_DEFAULT,
    parameter int RX_AW = RX_AW_DEFAULT
) (
    input  logic             clk_48mhz,
    input  logic             resetq,
    input  logic             host_presence,
    input  logic             tx_wr,
    input  logic [7:0]       tx_data,
    output logic             tx_full,
    output logic [TX_AW:0]   tx_level,
    input  logic             rx_rd,
    output logic [7:0]       rx_data,
    output logic             rx_empty,
    output logic [RX_AW:0]   rx_level,
    output logic             uart_wr,
    output logic [7:0]       uart_tx_data,
    input  logic             uart_busy,
    output logic             uart_rd,
    input  logic [7:0]       uart_rx_data,
    input  logic             uart_valid
);

    tx_state_t  tx_state, tx_state_next;
    rx_state_t  rx_state, rx_state_next;
    logic       tx_empty;
    logic [7:0] tx_head;
    logic       tx_flush;
    logic       tx_ready;
    logic       tx_fire;
    logic       rx_full;
    logic       rx_ready;
    logic       rx_fire;
    logic [7:0] rx_byte;

    // With no host enumerated the TX buffer is held empty and CPU writes vanish
    assign tx_flush = !host_presence;
    assign tx_ready = !tx_empty && !uart_busy && host_presence;
    assign rx_ready = uart_valid && !rx_full;

    byte_fifo #(.AW(TX_AW)) u_tx_fifo (
        .clk       (clk_48mhz),
        .rst_n     (resetq),
        .flush     (tx_flush),
        .push      (tx_wr),
        .push_data (tx_data),
        .pop       (tx_fire),
        .head_data (tx_head),
        .full      (tx_full),
        .empty     (tx_empty),
        .level     (tx_level)
    );

    // The registered byte taken from the core is pushed during the uart_rd cycle
    byte_fifo #(.AW(RX_AW)) u_rx_fifo (
        .clk       (clk_48mhz),
        .rst_n     (resetq),
        .flush     (1'b0),
        .push      (uart_rd),
        .push_data (rx_byte),
        .pop       (rx_rd),
        .head_data (rx_data),
        .full      (rx_full),
        .empty     (rx_empty),
        .level     (rx_level)
    );

    // TX drain state register
    always_ff @(posedge clk_48mhz or negedge resetq) begin
        if (!resetq) tx_state <= T_IDLE;
        else         tx_state <= tx_state_next;
    end

    // TX next state: the wait cycle covers the core's one-cycle busy latency
    // NOTE: combinational blocks assign a default first so no path infers a latch.
    always_comb begin
        tx_state_next = tx_state;
        case (tx_state)
            T_IDLE:  if (tx_ready) tx_state_next = T_WAIT;
            T_WAIT:  tx_state_next = T_IDLE;
            default: tx_state_next = T_IDLE;
        endcase
    end

    // TX output decode: pop the head when a transfer is launched
    always_comb begin
        tx_fire = (tx_state == T_IDLE) && tx_ready;
    end

    // TX write pulse and data to the core, registered for clean timing
    always_ff @(posedge clk_48mhz or negedge resetq) begin
        if (!resetq) begin
            uart_wr      <= 1'b0;
            uart_tx_data <= '0;
        end else begin
            uart_wr <= tx_fire;
            if (tx_fire) uart_tx_data <= tx_head;
        end
    end

    // RX fill state register
    always_ff @(posedge clk_48mhz or negedge resetq) begin
        if (!resetq) rx_state <= R_IDLE;
        else         rx_state <= rx_state_next;
    end

    // RX next state: the wait cycle lets uart_valid drop after the read pulse
    always_comb begin
        rx_state_next = rx_state;
        case (rx_state)
            R_IDLE:  if (rx_ready) rx_state_next = R_WAIT;
            R_WAIT:  rx_state_next = R_IDLE;
            default: rx_state_next = R_IDLE;
        endcase
    end

    // RX output decode: accept a byte only when there is room, else backpressure
    always_comb begin
        rx_fire = (rx_state == R_IDLE) && rx_ready;
    end

    // RX read pulse to the core and capture of the accepted byte
    always_ff @(posedge clk_48mhz or negedge resetq) begin
        if (!resetq) begin
            uart_rd <= 1'b0;
            rx_byte <= '0;
        end else begin
            uart_rd <= rx_fire;
            if (rx_fire) rx_byte <= uart_rx_data;
        end
    end

endmodule

// File: tb/tb_usb_uart_fifo.sv
// Scoreboard bench for usb_uart_fifo: stimulus pushes expected bytes into
// queues, a monitor pops and compares whenever the DUT emits a byte.
module tb_usb_uart_fifo;

    logic       clk_48mhz = 1'b0;
    logic       resetq;
    logic       host_presence;
    logic       tx_wr;
    logic [7:0] tx_data;
    logic       tx_full;
    logic [4:0] tx_level;
    logic       rx_rd;
    logic [7:0] rx_data;
    logic       rx_empty;
    logic [4:0] rx_level;
    logic       uart_wr;
    logic [7:0] uart_tx_data;
    logic       uart_busy;
    logic       uart_rd;
    logic [7:0] uart_rx_data;
    logic       uart_valid;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int wr_count = 0;
    int rd_count = 0;
    logic prev_wr = 1'b0;

    logic [7:0] tx_exp[$];
    logic [7:0] rx_exp[$];
    int         wr_cyc_q[$];

    // Core RX source model: presents rx_base+rx_idx while rx_idx < rx_n
    logic       rx_active = 1'b0;
    int         rx_idx = 0;
    int         rx_n = 0;
    logic [7:0] rx_base = 8'h00;

    assign uart_valid   = rx_active && (rx_idx < rx_n);
    assign uart_rx_data = rx_base + 8'(rx_idx);

    usb_uart_fifo dut (
        .clk_48mhz     (clk_48mhz),
        .resetq        (resetq),
        .host_presence (host_presence),
        .tx_wr         (tx_wr),
        .tx_data       (tx_data),
        .tx_full       (tx_full),
        .tx_level      (tx_level),
        .rx_rd         (rx_rd),
        .rx_data       (rx_data),
        .rx_empty      (rx_empty),
        .rx_level      (rx_level),
        .uart_wr       (uart_wr),
        .uart_tx_data  (uart_tx_data),
        .uart_busy     (uart_busy),
        .uart_rd       (uart_rd),
        .uart_rx_data  (uart_rx_data),
        .uart_valid    (uart_valid)
    );

    always #10 clk_48mhz = ~clk_48mhz;

    always @(posedge clk_48mhz) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk_48mhz);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Monitor: compares every byte the DUT emits against the scoreboard queues
    always @(negedge clk_48mhz) begin
        if (uart_wr) begin
            wr_count <= wr_count + 1;
            wr_cyc_q.push_back(cyc);
            check("wr_gap", {31'd0, prev_wr}, 32'd0);
            if (tx_exp.size() == 0) check("tx_unexpected", {24'd0, uart_tx_data}, 32'hFFFF_FFFF);
            else                    check("tx_byte", {24'd0, uart_tx_data}, {24'd0, tx_exp.pop_front()});
        end
        prev_wr <= uart_wr;
        if (uart_rd) begin
            rd_count <= rd_count + 1;
            rx_exp.push_back(rx_base + 8'(rx_idx));
            rx_idx <= rx_idx + 1;
        end
        if (rx_rd && !rx_empty) begin
            if (rx_exp.size() == 0) check("rx_unexpected", {24'd0, rx_data}, 32'hFFFF_FFFF);
            else                    check("rx_byte", {24'd0, rx_data}, {24'd0, rx_exp.pop_front()});
        end
    end

    task automatic push_tx(input logic [7:0] b, input logic expect_out);
        tx_wr   = 1'b1;
        tx_data = b;
        if (expect_out) tx_exp.push_back(b);
        step();
        tx_wr = 1'b0;
    endtask

    int k;
    int wr_base;
    int rd_base;

    initial begin
        resetq        = 1'b0;
        host_presence = 1'b0;
        tx_wr         = 1'b0;
        tx_data       = 8'h00;
        rx_rd         = 1'b0;
        uart_busy     = 1'b0;

        // Reset values
        steps(3);
        check("rst_uart_wr", {31'd0, uart_wr}, 32'd0);
        check("rst_uart_rd", {31'd0, uart_rd}, 32'd0);
        check("rst_tx_data", {24'd0, uart_tx_data}, 32'd0);
        check("rst_tx_full", {31'd0, tx_full}, 32'd0);
        check("rst_tx_level", {27'd0, tx_level}, 32'd0);
        check("rst_rx_empty", {31'd0, rx_empty}, 32'd1);
        check("rst_rx_level", {27'd0, rx_level}, 32'd0);
        resetq = 1'b1;
        host_presence = 1'b1;
        steps(20);
        check("idle_wr_count", wr_count, 0);
        check("idle_rd_count", rd_count, 0);
        check("idle_rx_empty", {31'd0, rx_empty}, 32'd1);
        check("idle_tx_level", {27'd0, tx_level}, 32'd0);

        // Back-to-back TX pushes: pulses every 2nd cycle, first 2 cycles after push
        wr_cyc_q.delete();
        k = cyc;
        push_tx(8'h41, 1'b1);
        push_tx(8'h42, 1'b1);
        push_tx(8'h43, 1'b1);
        steps(10);
        check("tx3_count", wr_cyc_q.size(), 3);
        if (wr_cyc_q.size() == 3) begin
            check("tx3_lat0", wr_cyc_q[0], k + 2);
            check("tx3_lat1", wr_cyc_q[1], k + 4);
            check("tx3_lat2", wr_cyc_q[2], k + 6);
        end

        // TX full: 17 pushes with core busy, the 17th is dropped
        uart_busy = 1'b1;
        wr_base = wr_count;
        for (int i = 0; i < 16; i++) push_tx(8'h50 + 8'(i), 1'b1);
        check("txf_full16", {31'd0, tx_full}, 32'd1);
        check("txf_level16", {27'd0, tx_level}, 32'd16);
        push_tx(8'h60, 1'b0);
        check("txf_full17", {31'd0, tx_full}, 32'd1);
        check("txf_level17", {27'd0, tx_level}, 32'd16);
        check("txf_no_wr", wr_count - wr_base, 0);
        uart_busy = 1'b0;
        steps(40);
        check("txf_drained", wr_count - wr_base, 16);
        check("txf_empty", {27'd0, tx_level}, 32'd0);

        // Host absence flushes TX and discards writes
        uart_busy = 1'b1;
        for (int i = 0; i < 5; i++) push_tx(8'h90 + 8'(i), 1'b0);
        check("host_level5", {27'd0, tx_level}, 32'd5);
        host_presence = 1'b0;
        step();
        check("host_flush", {27'd0, tx_level}, 32'd0);
        for (int i = 0; i < 3; i++) push_tx(8'hA0 + 8'(i), 1'b0);
        check("host_level0", {27'd0, tx_level}, 32'd0);
        check("host_full0", {31'd0, tx_full}, 32'd0);
        wr_base = wr_count;
        host_presence = 1'b1;
        uart_busy = 1'b0;
        steps(10);
        check("host_no_stale", wr_count - wr_base, 0);

        // TX at full: drain pop and CPU push in the same cycle keep level 16
        uart_busy = 1'b1;
        wr_base = wr_count;
        for (int i = 0; i < 16; i++) push_tx(8'h60 + 8'(i), 1'b1);
        check("txs_level16", {27'd0, tx_level}, 32'd16);
        uart_busy = 1'b0;
        push_tx(8'h70, 1'b1);
        check("txs_level_keep", {27'd0, tx_level}, 32'd16);
        check("txs_full_keep", {31'd0, tx_full}, 32'd1);
        steps(40);
        check("txs_drained", wr_count - wr_base, 17);

        // RX fill to full with backpressure, then one pop admits the 17th byte
        rd_base = rd_count;
        rx_base = 8'h00;
        rx_idx = 0;
        rx_n = 17;
        rx_active = 1'b1;
        steps(40);
        check("rx_rd16", rd_count - rd_base, 16);
        check("rx_level16", {27'd0, rx_level}, 32'd16);
        check("rx_nonempty", {31'd0, rx_empty}, 32'd0);
        rx_rd = 1'b1;
        step();
        rx_rd = 1'b0;
        steps(6);
        check("rx_rd17", rd_count - rd_base, 17);
        check("rx_level_refill", {27'd0, rx_level}, 32'd16);
        rx_rd = 1'b1;
        steps(16);
        rx_rd = 1'b0;
        step();
        check("rx_drained", {31'd0, rx_empty}, 32'd1);
        check("rx_level0", {27'd0, rx_level}, 32'd0);
        rx_active = 1'b0;

        // RX streaming: CPU pops every cycle while the FSM keeps pushing
        rd_base = rd_count;
        rx_base = 8'h80;
        rx_idx = 0;
        rx_n = 17;
        rx_active = 1'b1;
        steps(40);
        check("rxs_level16", {27'd0, rx_level}, 32'd16);
        rx_rd = 1'b1;
        steps(30);
        rx_rd = 1'b0;
        step();
        check("rxs_rd17", rd_count - rd_base, 17);
        check("rxs_empty", {31'd0, rx_empty}, 32'd1);
        rx_active = 1'b0;

        check("tx_queue_left", tx_exp.size(), 0);
        check("rx_queue_left", rx_exp.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/usb_uart_fifo.md
# usb_uart_fifo

Byte-buffering stage between the CPU I/O port and the USB CDC UART core (`usb_uart`), which exposes a one-byte-at-a-time `uart_wr`/`uart_busy` and `uart_valid`/`uart_rd` handshake. The block holds a TX FIFO, drained into the core whenever it is idle, and an RX FIFO, filled from the core whenever it has a byte. The CPU gets level/flag status and non-blocking access. Everything runs in the 48 MHz USB clock domain.

## Interface
- `TX_AW`, default 4: log2 of TX FIFO depth (16 bytes).
- `RX_AW`, default 4: log2 of RX FIFO depth (16 bytes).

Ports:
- `clk_48mhz`  in  1  sole clock.
- `resetq`  in  1  asynchronous, active-low reset.
- `host_presence`  in  1  from the core; high while the USB host is enumerated.
- `tx_wr`  in  1  CPU push strobe, one cycle per byte.
- `tx_data`  in  8  byte pushed on `tx_wr`.
- `tx_full`  out  1  TX FIFO full.
- `tx_level`  out  TX_AW+1  bytes held in TX FIFO.
- `rx_rd`  in  1  CPU pop strobe.
- `rx_data`  out  8  head of RX FIFO (show-ahead).
- `rx_empty`  out  1  RX FIFO empty.
- `rx_level`  out  RX_AW+1  bytes held in RX FIFO.
- `uart_wr`  out  1  write pulse to core.
- `uart_tx_data`  out  8  byte to core, valid while `uart_wr` is high.
- `uart_busy`  in  1  core cannot accept a byte.
- `uart_rd`  out  1  read pulse to core.
- `uart_rx_data`  in  8  byte from core.
- `uart_valid`  in  1  core holds an unread byte.

## Operation
- Both FIFOs are circular buffers with AW-bit pointers and an (AW+1)-bit count. Full means count == 2^AW. Empty means count == 0.
- Push when full: ignored, no state change. Pop when empty: ignored.
- Push and pop in the same cycle: both take effect and the count is unchanged. This also holds when the FIFO is full (pop frees the slot the push fills). When empty, the pop is ignored and the push takes effect.
- TX drain FSM, states `T_IDLE`, `T_WAIT`:
  - `T_IDLE`: if the FIFO is non-empty, `uart_busy` is low and `host_presence` is high, then assert `uart_wr` for one cycle with the head byte on `uart_tx_data`, pop the head, and go to `T_WAIT`.
  - `T_WAIT`: one cycle unconditionally, which absorbs the core's one-cycle `uart_busy` latency. Then go to `T_IDLE`.
- Host absent: while `host_presence` is low, the TX FIFO is held flushed (count 0) and `tx_wr` is discarded. `tx_full` stays 0, so CPU writes never block.
- RX fill FSM, states `R_IDLE`, `R_WAIT`:
  - `R_IDLE`: if `uart_valid` is high and the RX FIFO is not full, push `uart_rx_data`, assert `uart_rd` for one cycle, and go to `R_WAIT`.
  - `R_WAIT`: one cycle, for `uart_valid` to drop. Then go to `R_IDLE`.
- When the RX FIFO is full, the byte stays in the core and `uart_rd` is withheld (backpressure to the USB OUT endpoint). No data is dropped.
- A CPU pop and an FSM push on the same cycle follow the simultaneity rule above.

## Timing
- Reset values: `uart_wr`=0, `uart_rd`=0, `uart_tx_data`=0, `tx_full`=0, `tx_level`=0, `rx_empty`=1, `rx_level`=0, both FSMs in IDLE. `rx_data` is don't-care while empty.
- Reset mid-operation discards all buffered bytes. A `uart_wr` or `uart_rd` pulse in flight is cut off at reset assertion.
- `tx_full`, `tx_level`, `rx_empty`, `rx_level` are registered and update the cycle after the push or pop.
- `rx_data` is a combinational read of the head slot and changes the cycle after a pop.
- TX latency: a byte pushed into an empty FIFO with the core idle appears as `uart_wr` two cycles after `tx_wr`.
- TX throughput: at most one byte per 2 cycles.
- RX latency: a byte with `uart_valid` high at cycle n is visible on `rx_data` (`rx_empty` low) at n+2. RX throughput: at most one byte per 2 cycles.
- `uart_wr` and `uart_rd` are always single-cycle pulses and are never asserted on consecutive cycles.

## Structure
- The sub-module `byte_fifo` (parameter AW) holds the memory, pointers, count and flags. It is instantiated twice and carries the flush input used by `host_presence`.
- Shared package: FSM state encodings (`T_IDLE`/`T_WAIT`, `R_IDLE`/`R_WAIT`) and the default `TX_AW`/`RX_AW`. The FSMs themselves stay in `usb_uart_fifo`.

## Test plan
- Reset with `resetq`=0, then release → `rx_empty`=1, `tx_level`=0, no `uart_wr`/`uart_rd` for 20 cycles with `uart_valid`=0.
- With `host_presence`=1 and `uart_busy`=0, push 0x41,0x42,0x43 back-to-back → `uart_wr` pulses every 2nd cycle carrying 0x41,0x42,0x43 in order, first pulse 2 cycles after the first push.
- Push 17 bytes with `uart_busy` held 1 → `tx_full`=1 at level 16 and the 17th byte is dropped. Release `uart_busy` → exactly the first 16 bytes emerge.
- Push 5 bytes, then drop `host_presence` → `tx_level`=0 next cycle, and further pushes leave `tx_level` at 0 and `tx_full` at 0.
- Hold `uart_valid`=1 while presenting 0x00..0x10 as each is taken, with no CPU pops → 16 `uart_rd` pulses, `rx_level`=16, no 17th `uart_rd`. Pop once → 17th byte 0x10 accepted; pops return 0x00..0x10 in order.
- RX FIFO at level 16 with `rx_rd` and an FSM push in the same cycle → level stays 16 and order is preserved.
